// File: rtl/dma_axi_pkg.sv
// Shared constants and state encodings for the DMA AXI3 slave memory.
package dma_axi_pkg;

  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

endpackage

// File: rtl/dma_axi_slv_mem_if.sv
// AXI3 64-bit channel bundle between the DMA master and the slave memory.
interface dma_axi_slv_mem_if #(
  parameter int unsigned ID_W   = dma_axi_pkg::AXI_ID_W,
  parameter int unsigned ADDR_W = dma_axi_pkg::AXI_ADDR_W
);
  import dma_axi_pkg::*;

  logic [ID_W-1:0]       awid;
  logic [ADDR_W-1:0]     awaddr;
  logic [3:0]            awlen;
  logic [2:0]            awsize;
  logic                  awvalid;
  logic                  awready;
  logic [ID_W-1:0]       wid;
  logic [AXI_DATA_W-1:0] wdata;
  logic [7:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_W-1:0]       bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ID_W-1:0]       arid;
  logic [ADDR_W-1:0]     araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic                  arvalid;
  logic                  arready;
  logic [ID_W-1:0]       rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid,     output wready,
    output bid, bresp, bvalid,                   input  bready,
    input  arid, araddr, arlen, arsize, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid,     input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awvalid, input  awready,
    output wid, wdata, wstrb, wlast, wvalid,     input  wready,
    input  bid, bresp, bvalid,                   output bready,
    output arid, araddr, arlen, arsize, arvalid, input  arready,
    input  rid, rdata, rresp, rlast, rvalid,     output rready
  );

endinterface

// File: rtl/dma_axi_slv_ram.sv
// DEPTH x 64 word store: byte-enabled write port, registered read port.
// A read and a write to the same word on one edge return the old word.
module dma_axi_slv_ram
  import dma_axi_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [AXI_DATA_W-1:0] wdata,
  input  logic [7:0]            wstrb,
  input  logic                  re,
  input  logic [IDX_W-1:0]      ridx,
  output logic [AXI_DATA_W-1:0] rdata
);

  logic [AXI_DATA_W-1:0] mem_q [DEPTH];
  logic [AXI_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem_q[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata_q <= mem_q[ridx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dma_axi_slv_mem.sv
// AXI3 64-bit slave memory for the DMA master port: one outstanding INCR
// burst per direction, per-beat range check, SLVERR on illegal size or range.
module dma_axi_slv_mem
  import dma_axi_pkg::*;
#(
  parameter int unsigned       ID_W      = AXI_ID_W,
  parameter int unsigned       ADDR_W    = AXI_ADDR_W,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic              clk,
  input logic              reset,
  dma_axi_slv_mem_if.slave axi
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  function automatic logic beat_ok(input logic [ADDR_W-1:0] addr, input logic [2:0] size);
    return (size <= 3'd3) && (addr >= BASE_ADDR) &&
           (((addr - BASE_ADDR) >> 3) < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [ADDR_W-1:0] beat_step(input logic [2:0] size);
    return ADDR_W'(1) << size;
  endfunction

  w_state_t              w_state_q, w_state_d;
  logic [ID_W-1:0]       awid_q, awid_d, bid_q, bid_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [3:0]            wlen_q, wlen_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [4:0]            wbeat_q, wbeat_d;
  logic                  werr_q, werr_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_good, w_at_len, ram_we;

  r_state_t              r_state_q, r_state_d;
  logic [ID_W-1:0]       rid_q, rid_d;
  logic [ADDR_W-1:0]     raddr_q, raddr_d, rd_addr;
  logic [3:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]            rsize_q, rsize_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic                  rok_q, rok_d, rd_en;
  logic [1:0]            rresp_q, rresp_d;
  logic [AXI_DATA_W-1:0] ram_rdata;

  always_comb begin
    w_state_d = w_state_q; awid_d  = awid_q;  waddr_d   = waddr_q;   wlen_d   = wlen_q;
    wsize_d   = wsize_q;   wbeat_d = wbeat_q; werr_d    = werr_q;    bid_d    = bid_q;
    awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q; bresp_d  = bresp_q;
    w_good    = 1'b0;      w_at_len = 1'b0;   ram_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (awready_q && axi.awvalid) begin
        awid_d = axi.awid; waddr_d = axi.awaddr; wlen_d = axi.awlen; wsize_d = axi.awsize;
        wbeat_d = '0; werr_d = 1'b0; awready_d = 1'b0; wready_d = 1'b1; w_state_d = W_DATA;
      end
      W_DATA: if (wready_q && axi.wvalid) begin
        // Beats beyond len (missing wlast) are swallowed until wlast shows up.
        w_at_len = (wbeat_q == {1'b0, wlen_q});
        w_good   = (wbeat_q <= {1'b0, wlen_q}) && beat_ok(waddr_q, wsize_q);
        ram_we   = reset && w_good;
        werr_d   = werr_q || !w_good || (axi.wlast != w_at_len);
        waddr_d  = waddr_q + beat_step(wsize_q);
        wbeat_d  = (wbeat_q == 5'd31) ? wbeat_q : wbeat_q + 5'd1;
        if (axi.wlast) begin
          wready_d = 1'b0; bvalid_d = 1'b1; bid_d = awid_q; w_state_d = W_RESP;
          bresp_d  = werr_d ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (axi.bready) begin
        bvalid_d = 1'b0; awready_d = 1'b1; w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q; rid_d   = rid_q;   raddr_d = raddr_q; rlen_d    = rlen_q;
    rsize_d   = rsize_q;   rbeat_d = rbeat_q; rok_d   = rok_q;   rresp_d   = rresp_q;
    arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
    rd_en     = 1'b0;      rd_addr = axi.araddr;
    case (r_state_q)
      R_IDLE: if (arready_q && axi.arvalid) begin
        rid_d = axi.arid; raddr_d = axi.araddr; rlen_d = axi.arlen; rsize_d = axi.arsize;
        rbeat_d = '0; rlast_d = (axi.arlen == 4'd0); rok_d = beat_ok(axi.araddr, axi.arsize);
        rresp_d = rok_d ? RESP_OKAY : RESP_SLVERR;
        arready_d = 1'b0; rvalid_d = 1'b1; rd_en = 1'b1; r_state_d = R_DATA;
      end
      R_DATA: if (rvalid_q && axi.rready) begin
        if (rlast_q) begin
          rvalid_d = 1'b0; arready_d = 1'b1; r_state_d = R_IDLE;
        end else begin
          // Prefetch the next beat on this handshake edge so rready=1 streams bubble-free.
          rd_addr = raddr_q + beat_step(rsize_q);
          raddr_d = rd_addr; rbeat_d = rbeat_q + 4'd1; rlast_d = (rbeat_d == rlen_q);
          rok_d   = beat_ok(rd_addr, rsize_q);
          rresp_d = rok_d ? RESP_OKAY : RESP_SLVERR;
          rd_en   = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state_q <= W_IDLE; awid_q <= '0; waddr_q <= '0; wlen_q <= '0; wsize_q <= '0;
      wbeat_q <= '0; werr_q <= 1'b0; bid_q <= '0; bresp_q <= '0;
      awready_q <= 1'b1; wready_q <= 1'b0; bvalid_q <= 1'b0;
      r_state_q <= R_IDLE; rid_q <= '0; raddr_q <= '0; rlen_q <= '0; rsize_q <= '0;
      rbeat_q <= '0; rok_q <= 1'b0; rresp_q <= '0;
      arready_q <= 1'b1; rvalid_q <= 1'b0; rlast_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d; awid_q <= awid_d; waddr_q <= waddr_d; wlen_q <= wlen_d;
      wsize_q <= wsize_d; wbeat_q <= wbeat_d; werr_q <= werr_d; bid_q <= bid_d;
      bresp_q <= bresp_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      r_state_q <= r_state_d; rid_q <= rid_d; raddr_q <= raddr_d; rlen_q <= rlen_d;
      rsize_q <= rsize_d; rbeat_q <= rbeat_d; rok_q <= rok_d; rresp_q <= rresp_d;
      arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
    end
  end

  dma_axi_slv_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .widx  (word_idx(waddr_q)),
    .wdata (axi.wdata),
    .wstrb (axi.wstrb),
    .re    (rd_en),
    .ridx  (word_idx(rd_addr)),
    .rdata (ram_rdata)
  );

  logic unused_wid;
  assign unused_wid = ^axi.wid;

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rid     = rid_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
  assign axi.rdata   = rok_q ? ram_rdata : '0;

endmodule
